img_mem_fsm: RTL and testbench

IMG_MEM_FSM -- requirements
Module: img_mem_fsm

---
 rtl/img_mem_fsm.sv | 130 +++++++++++++
 tb/tb_img_mem_fsm.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/img_mem_fsm.sv
// Image memory sequencer: loads up to N words into the image BRAM, replays them
// to the convolver in one contiguous burst, then serves result-memory readback addresses.
module img_mem_fsm #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input  logic              i_CLK,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic              i_run,
  input  logic [ADDR_W-1:0] i_imgLength,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic              o_conv_valid,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_EOP,
  output logic [1:0]        o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_n;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_len;
  logic              r_run_pend;
  logic              r_rd_active;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_conv_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_eop;

  logic              w_wr_accept;
  logic              w_last_rd;
  logic              w_out_wrap;

  assign w_wr_accept = i_valid && (r_cnt < r_n);
  assign w_last_rd   = (r_raddr == r_len - 1'b1);
  // Also wraps to 0 when L is 0 or 1, so the readback address never leaves the frame.
  assign w_out_wrap  = ((r_out_addr + 1'b1) >= r_len);

  always_ff @(posedge i_CLK) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_cnt        <= '0;
      r_len        <= '0;
      r_run_pend   <= 1'b0;
      r_rd_active  <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
      r_raddr      <= '0;
      r_conv_valid <= 1'b0;
      r_out_addr   <= '0;
      r_eop        <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_conv_valid <= 1'b0;
      if (i_load) begin
        r_state     <= S_LOAD;
        r_n         <= i_imgLength;
        r_cnt       <= '0;
        r_out_addr  <= '0;
        r_eop       <= 1'b0;
        r_run_pend  <= 1'b0;
        r_rd_active <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            // A write accepted alongside i_run lands first; RUN starts one cycle later with it counted.
            if (w_wr_accept) begin
              r_we    <= 1'b1;
              r_waddr <= r_cnt;
              r_wdata <= i_data;
              r_cnt   <= r_cnt + 1'b1;
              if (i_run) r_run_pend <= 1'b1;
            end else if (i_run || r_run_pend) begin
              r_run_pend <= 1'b0;
              r_len      <= r_cnt;
              r_raddr    <= '0;
              if (r_cnt == '0) begin
                r_state <= S_DONE;
                r_eop   <= 1'b1;
              end else begin
                r_state     <= S_RUN;
                r_rd_active <= 1'b1;
              end
            end
          end
          S_RUN: begin
            // One address per cycle; a final tail cycle lets the last read's valid go out before DONE.
            if (r_rd_active) begin
              r_conv_valid <= 1'b1;
              if (w_last_rd) r_rd_active <= 1'b0;
              else           r_raddr     <= r_raddr + 1'b1;
            end else begin
              r_state <= S_DONE;
              r_eop   <= 1'b1;
            end
          end
          S_DONE: begin
            if (i_valid) r_out_addr <= w_out_wrap ? '0 : r_out_addr + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_we     = r_we;
  assign o_mem_waddr  = r_waddr;
  assign o_mem_wdata  = r_wdata;
  assign o_mem_raddr  = r_raddr;
  assign o_conv_valid = r_conv_valid;
  assign o_out_addr   = r_out_addr;
  assign o_EOP        = r_eop;
  assign o_state      = r_state;

endmodule

// File: tb/tb_img_mem_fsm.sv
// Directed bench for img_mem_fsm: load/run/readback sequences with hand-derived cycle timing.
module tb_img_mem_fsm;
  localparam int DW = 24;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_load = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_run = 1'b0;
  logic [AW-1:0] i_img_length = '0;
  logic [DW-1:0] i_data = '0;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_waddr;
  logic [DW-1:0] o_mem_wdata;
  logic [AW-1:0] o_mem_raddr;
  logic          o_conv_valid;
  logic [AW-1:0] o_out_addr;
  logic          o_eop;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  img_mem_fsm #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_CLK(clk), .i_rst_n(i_rst_n), .i_load(i_load), .i_valid(i_valid), .i_run(i_run),
    .i_imgLength(i_img_length), .i_data(i_data),
    .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
    .o_mem_raddr(o_mem_raddr), .o_conv_valid(o_conv_valid), .o_out_addr(o_out_addr),
    .o_EOP(o_eop), .o_state(o_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pre);
    check({pre, "_we"},    32'(o_mem_we), 32'd0);
    check({pre, "_waddr"}, 32'(o_mem_waddr), 32'd0);
    check({pre, "_wdata"}, 32'(o_mem_wdata), 32'd0);
    check({pre, "_raddr"}, 32'(o_mem_raddr), 32'd0);
    check({pre, "_conv"},  32'(o_conv_valid), 32'd0);
    check({pre, "_oaddr"}, 32'(o_out_addr), 32'd0);
    check({pre, "_eop"},   32'(o_eop), 32'd0);
    check({pre, "_state"}, 32'(o_state), 32'd0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_load(input int n);
    i_load = 1'b1;
    i_img_length = AW'(n);
    step();
    i_load = 1'b0;
    check("load_state", 32'(o_state), 32'd1);
    check("load_eop", 32'(o_eop), 32'd0);
    check("load_oaddr", 32'(o_out_addr), 32'd0);
  endtask

  task automatic push(input logic [DW-1:0] data, input bit accept, input int addr);
    i_valid = 1'b1;
    i_data = data;
    if (accept) exp_q.push_back(data);
    step();
    i_valid = 1'b0;
    check("wr_we", 32'(o_mem_we), 32'(accept));
    if (accept) begin
      check("wr_addr", 32'(o_mem_waddr), 32'(addr));
      check("wr_data", 32'(o_mem_wdata), 32'(exp_q.pop_front()));
    end
    step();
    check("wr_gap_we", 32'(o_mem_we), 32'd0);
  endtask

  task automatic run_seq(input int len);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    if (len == 0) begin
      check("run0_state", 32'(o_state), 32'd3);
      check("run0_eop", 32'(o_eop), 32'd1);
      check("run0_conv", 32'(o_conv_valid), 32'd0);
      return;
    end
    check("run_state", 32'(o_state), 32'd2);
    check("run_raddr0", 32'(o_mem_raddr), 32'd0);
    check("run_conv0", 32'(o_conv_valid), 32'd0);
    for (int k = 1; k < len; k++) begin
      i_valid = 1'(k % 2);
      step();
      check("run_raddr", 32'(o_mem_raddr), 32'(k));
      check("run_conv", 32'(o_conv_valid), 32'd1);
      check("run_we", 32'(o_mem_we), 32'd0);
      check("run_eop", 32'(o_eop), 32'd0);
    end
    i_valid = 1'b0;
    step();
    check("run_last_conv", 32'(o_conv_valid), 32'd1);
    check("run_last_eop", 32'(o_eop), 32'd0);
    check("run_last_state", 32'(o_state), 32'd2);
    step();
    check("run_end_conv", 32'(o_conv_valid), 32'd0);
    check("run_end_eop", 32'(o_eop), 32'd1);
    check("run_end_state", 32'(o_state), 32'd3);
  endtask

  initial begin
    logic [AW-1:0] exp_oaddr [4];
    exp_oaddr = '{10'd1, 10'd2, 10'd0, 10'd1};

    do_reset();
    check_reset_vals("rst");

    // IDLE ignores valid/run
    i_valid = 1'b1;
    i_run = 1'b1;
    step();
    i_valid = 1'b0;
    i_run = 1'b0;
    check("idle_state", 32'(o_state), 32'd0);
    check("idle_we", 32'(o_mem_we), 32'd0);

    // N=4, four words, full run
    do_load(4);
    push(24'h010203, 1'b1, 0);
    push(24'h040506, 1'b1, 1);
    push(24'h070809, 1'b1, 2);
    push(24'h0A0B0C, 1'b1, 3);
    run_seq(4);

    // N=2, third word dropped
    do_load(2);
    push(24'h111111, 1'b1, 0);
    push(24'h222222, 1'b1, 1);
    push(24'h333333, 1'b0, 0);
    run_seq(2);

    // N=8, partial frame L=3
    do_load(8);
    push(24'hA00001, 1'b1, 0);
    push(24'hA00002, 1'b1, 1);
    push(24'hA00003, 1'b1, 2);
    run_seq(3);
    step();
    check("done_eop_hold", 32'(o_eop), 32'd1);

    // DONE readback with wrap at L=3
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      check("oaddr", 32'(o_out_addr), 32'(exp_oaddr[i]));
      check("oaddr_eop", 32'(o_eop), 32'd1);
      step();
    end

    // N=5, run with nothing loaded
    do_load(5);
    run_seq(0);
    step();
    check("empty_conv", 32'(o_conv_valid), 32'd0);
    check("empty_eop", 32'(o_eop), 32'd1);

    // N=0: every write ignored
    do_load(0);
    push(24'h555555, 1'b0, 0);
    run_seq(0);

    // valid and run in the same cycle: write lands first, counted in L
    do_load(4);
    i_valid = 1'b1;
    i_run = 1'b1;
    i_data = 24'hBEEF01;
    step();
    i_valid = 1'b0;
    i_run = 1'b0;
    check("vr_we", 32'(o_mem_we), 32'd1);
    check("vr_addr", 32'(o_mem_waddr), 32'd0);
    check("vr_data", 32'(o_mem_wdata), 32'hBEEF01);
    check("vr_state", 32'(o_state), 32'd1);
    run_seq(1);

    // reset beats load/valid in the same cycle
    i_rst_n = 1'b0;
    i_load = 1'b1;
    i_valid = 1'b1;
    i_img_length = 10'd7;
    step();
    i_rst_n = 1'b1;
    i_load = 1'b0;
    i_valid = 1'b0;
    check_reset_vals("rst_prio");

    // reset in the middle of RUN at raddr 5 of N=10
    do_load(10);
    for (int i = 0; i < 10; i++) push(DW'(24'hC00000 + i), 1'b1, i);
    i_run = 1'b1;
    step();
    i_run = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    check("mid_raddr", 32'(o_mem_raddr), 32'd5);
    check("mid_conv", 32'(o_conv_valid), 32'd1);
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    check_reset_vals("mid_run");
    step();
    check("post_rst_state", 32'(o_state), 32'd0);
    check("post_rst_conv", 32'(o_conv_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
